// File: rtl/gb_host_pkg.sv
// rtl/gb_host_pkg.sv - shared state encoding and constants for the ghostbus host
package gb_host_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      RD_WAIT = 2'd2,
      RSP     = 2'd3
   } gb_state_t;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int RD_DELAY_MAX = 15;
   localparam int DLY_W        = 4;

endpackage

// File: rtl/gb_sat_counter.sv
// rtl/gb_sat_counter.sv - saturating event counter with synchronous clear
module gb_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Clear has priority over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/gb_host.sv
// rtl/gb_host.sv - ghostbus host command/response sequencer
// Optional GB_HOST_STATS_EN adds saturating write/read beat counters.
module gb_host
   import gb_host_pkg::*;
#(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter int RD_DELAY = 2,
   parameter int LW       = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   input  logic [LW-1:0] cmd_len,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_last,
   output logic [AW-1:0] gb_addr,
   output logic [DW-1:0] gb_dout,
   output logic          gb_we,
   input  logic [DW-1:0] gb_din,
`ifdef GB_HOST_STATS_EN
   input  logic          stat_clr,
   output logic [31:0]   stat_wr_beats,
   output logic [31:0]   stat_rd_beats,
`endif
   output logic          busy
);

   localparam logic [LW:0]      BEAT_ONE = (LW+1)'(1);
   localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
   localparam logic [DLY_W-1:0] DLY_END  = DLY_W'(RD_DELAY);

   gb_state_t        state;
   logic [AW-1:0]    addr;
   logic [LW-1:0]    len;
   logic [LW:0]      beat;
   logic [LW:0]      beat_nx;
   logic [DLY_W-1:0] dly;
   logic             last_beat;

   // Beat counter is one bit wider than len so a full 2^LW burst cannot wrap it.
   assign beat_nx   = beat + BEAT_ONE;
   assign last_beat = (beat == {1'b0, len});
   assign cmd_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         len       <= '0;
         beat      <= '0;
         dly       <= '0;
         gb_addr   <= '0;
         gb_dout   <= '0;
         gb_we     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr    <= cmd_addr;
                  len     <= cmd_len;
                  beat    <= '0;
                  gb_addr <= cmd_addr;
                  if (cmd_write == OP_WRITE) begin
                     state   <= WR;
                     gb_we   <= 1'b1;
                     gb_dout <= cmd_wdata;
                  end else begin
                     state   <= RD_WAIT;
                     gb_dout <= '0;
                     dly     <= DLY_ONE;
                  end
               end
            end
            WR: begin
               if (last_beat) begin
                  gb_we <= 1'b0;
                  state <= IDLE;
               end else begin
                  beat    <= beat_nx;
                  gb_addr <= addr + AW'(beat_nx);
               end
            end
            RD_WAIT: begin
               // Address has been held RD_DELAY cycles when dly reaches DLY_END.
               if (dly == DLY_END) begin
                  rsp_data  <= gb_din;
                  rsp_last  <= last_beat;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
               end else begin
                  dly <= dly + DLY_ONE;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_last) begin
                     state <= IDLE;
                  end else begin
                     beat    <= beat_nx;
                     gb_addr <= addr + AW'(beat_nx);
                     dly     <= DLY_ONE;
                     state   <= RD_WAIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GB_HOST_STATS_EN
   gb_sat_counter #(.WIDTH(32)) u_wr_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (stat_clr),
      .inc   (gb_we),
      .count (stat_wr_beats)
   );

   gb_sat_counter #(.WIDTH(32)) u_rd_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (stat_clr),
      .inc   (rsp_valid && rsp_ready),
      .count (stat_rd_beats)
   );
`endif

endmodule

// File: tb/tb_gb_host.sv
// tb/tb_gb_host.sv - directed scoreboard bench for gb_host
module tb_gb_host;

    localparam int AW       = 12;
    localparam int DW       = 32;
    localparam int RD_DELAY = 2;
    localparam int LW       = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_dout;
    logic          gb_we;
    logic [DW-1:0] gb_din;
    logic          busy;
`ifdef GB_HOST_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_wr_beats;
    logic [31:0]   stat_rd_beats;
`endif

    always #5 clk = ~clk;

    gb_host #(.AW(AW), .DW(DW), .RD_DELAY(RD_DELAY), .LW(LW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_len       (cmd_len),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .gb_addr       (gb_addr),
        .gb_dout       (gb_dout),
        .gb_we         (gb_we),
        .gb_din        (gb_din),
`ifdef GB_HOST_STATS_EN
        .stat_clr      (stat_clr),
        .stat_wr_beats (stat_wr_beats),
        .stat_rd_beats (stat_rd_beats),
`endif
        .busy          (busy)
    );

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    assign gb_din = mem[gb_addr];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t wr_q[$];
    beat_t rd_q[$];
    int    n_chk = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (gb_we === 1'b1) mem[gb_addr] = gb_dout;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [LW-1:0] len);
        int n;
        n = 0;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = len;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
        chk("rsp_wait_expired", (waited >= 64), 1'b0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LW-1:0] len);
        beat_t b;
        for (int i = 0; i <= int'(len); i++) begin
            b.a = a + AW'(i);
            b.d = d;
            b.l = (i == int'(len));
            wr_q.push_back(b);
            ref_mem[b.a] = d;
        end
        issue(1'b1, a, d, len);
        while (wr_q.size() > 0) begin
            b = wr_q.pop_front();
            chk("wr_we", gb_we, 1'b1);
            chk("wr_addr", gb_addr, b.a);
            chk("wr_data", gb_dout, b.d);
            tick();
        end
        chk("wr_we_end", gb_we, 1'b0);
        chk("wr_ready_end", cmd_ready, 1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len, input int stall);
        beat_t b;
        int    waited;
        for (int i = 0; i <= int'(len); i++) begin
            b.a = a + AW'(i);
            b.d = ref_mem[b.a];
            b.l = (i == int'(len));
            rd_q.push_back(b);
        end
        rsp_ready = (stall == 0);
        issue(1'b0, a, '0, len);
        while (rd_q.size() > 0) begin
            b = rd_q.pop_front();
            wait_valid(waited);
            chk("rd_latency", waited, RD_DELAY);
            chk("rd_data", rsp_data, b.d);
            chk("rd_last", rsp_last, b.l);
            chk("rd_addr", gb_addr, b.a);
            chk("rd_we", gb_we, 1'b0);
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("stall_valid", rsp_valid, 1'b1);
                chk("stall_data", rsp_data, b.d);
                chk("stall_addr", gb_addr, b.a);
                chk("stall_cmd_ready", cmd_ready, 1'b0);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = (stall == 0);
        end
        chk("rd_done_valid", rsp_valid, 1'b0);
        chk("rd_done_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'hC0DE_0000 + i;
            ref_mem[i] = 32'hC0DE_0000 + i;
        end
        mem[12'h201]     = 32'hdadb00b5;
        ref_mem[12'h201] = 32'hdadb00b5;

        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h3F0;
        cmd_wdata = 32'h0000_0077;
        cmd_len   = '0;
        rsp_ready = 1'b1;
`ifdef GB_HOST_STATS_EN
        stat_clr  = 1'b0;
`endif
        tick();
        tick();
        tick();
        chk("rst_gb_we", gb_we, 1'b0);
        chk("rst_gb_addr", gb_addr, 12'h000);
        chk("rst_gb_dout", gb_dout, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_last", rsp_last, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);

        rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        ref_mem[12'h3F0] = 32'h0000_0077;
        chk("first_accept_we", gb_we, 1'b1);
        chk("first_accept_addr", gb_addr, 12'h3F0);
        chk("first_accept_busy", busy, 1'b1);
        tick();
        chk("first_accept_done", gb_we, 1'b0);

        do_write(12'h000, 32'h0000_0025, 8'd0);
        do_read(12'h201, 8'd0, 0);
        do_read(12'h3F0, 8'd0, 0);
        do_write(12'h240, 32'h0, 8'd63);
        do_read(12'h240, 8'd7, 0);
        do_read(12'h100, 8'd3, 5);
        do_read(12'hFFE, 8'd3, 0);

        rsp_ready = 1'b1;
        issue(1'b0, 12'hFFE, '0, 8'd3);
        wait_valid(waited);
        chk("abort_b1_data", rsp_data, ref_mem[12'hFFE]);
        tick();
        rsp_ready = 1'b0;
        wait_valid(waited);
        chk("abort_b2_addr", gb_addr, 12'hFFF);
        rst = 1'b1;
        tick();
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_gb_we", gb_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_rsp", rsp_valid, 1'b0);
        chk("abort_idle", busy, 1'b0);

        issue(1'b1, 12'h300, 32'h0000_005A, 8'd9);
        tick();
        chk("wabort_we_before", gb_we, 1'b1);
        rst = 1'b1;
        tick();
        chk("wabort_we", gb_we, 1'b0);
        rst = 1'b0;
        tick();
        chk("wabort_we_after", gb_we, 1'b0);
        chk("wabort_idle", busy, 1'b0);

        do_read(12'h010, 8'd0, 0);

`ifdef GB_HOST_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        do_write(12'h010, 32'h0000_00AB, 8'd2);
        do_read(12'h010, 8'd1, 0);
        chk("stat_wr", stat_wr_beats, 32'd3);
        chk("stat_rd", stat_rd_beats, 32'd2);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("stat_wr_clr", stat_wr_beats, 32'd0);
        chk("stat_rd_clr", stat_rd_beats, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
